// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the shared-multiplier scheduler.
package mul_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int A_W_DEF   = 4;
  localparam int B_W_DEF   = 3;
  localparam int C_W_DEF   = A_W_DEF + B_W_DEF;
  localparam int CNT_W_DEF = 16;

  // Requester index width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_width(N_REQ_DEF);

  // One returned result: full-width product plus originating requester.
  typedef struct packed {
    logic [C_W_DEF-1:0]  data;
    logic [ID_W_DEF-1:0] id;
  } res_rec_t;

endpackage

// File: rtl/mul_sched_if.sv
// Request and result bundle between the channel logic and mul_sched.
//
// Handshake: a transfer happens on a rising sysclk edge where valid and
// ready are both high. A source keeps valid and its payload stable until
// that edge; ready may depend on valid, valid never depends on ready.
interface mul_sched_if #(
  parameter int N_REQ = mul_sched_pkg::N_REQ_DEF,
  parameter int A_W   = mul_sched_pkg::A_W_DEF,
  parameter int B_W   = mul_sched_pkg::B_W_DEF,
  parameter int CNT_W = mul_sched_pkg::CNT_W_DEF
);
  import mul_sched_pkg::*;

  localparam int C_W  = A_W + B_W;
  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic [N_REQ-1:0]     req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [C_W-1:0]       res_data;
  logic [ID_W-1:0]      res_id;
  logic                 busy;
  logic [CNT_W-1:0]     op_count;

  // Requesters and the result consumer.
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, busy, op_count
  );

  // The scheduler itself.
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, busy, op_count
  );

endinterface

// File: rtl/mul_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping modulo N_REQ. Purely combinational; the pointer lives in the
// caller so it only moves on an actual accept.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  // Scan from the farthest offset down to ptr itself so the last hit
  // written is the closest one to ptr, i.e. the highest priority.
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        idx = ID_W'(j);
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mul_sched.sv
// Shared-multiplier scheduler: round-robin arbitration of N_REQ requesters
// onto one registered multiplier, two register stages (issue, result),
// products returned in accept order tagged with the requester index.
module mul_sched import mul_sched_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         sysclk,
  input  logic         rst,
  mul_sched_if.slave   bus
);

  localparam int C_W  = A_W + B_W;
  localparam int ID_W = id_width(N_REQ);

  // Issue stage.
  logic            s1_valid;
  logic [A_W-1:0]  s1_a;
  logic [B_W-1:0]  s1_b;
  logic [ID_W-1:0] s1_id;

  // Result stage.
  logic            res_valid_q;
  logic [C_W-1:0]  res_data_q;
  logic [ID_W-1:0] res_id_q;

  // Arbitration pointer and accept counter.
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] op_count_q;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;

  logic             res_free;
  logic             s1_adv;
  logic             s1_free;
  logic             accept;
  logic [A_W-1:0]   sel_a;
  logic [B_W-1:0]   sel_b;
  logic [C_W-1:0]   product;
  logic [ID_W-1:0]  ptr_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Stage advance: each stage can drain and refill in the same cycle, which
  // is what sustains one operation per cycle under continuous res_ready.
  assign res_free = !res_valid_q || bus.res_ready;
  assign s1_adv   = s1_valid && res_free;
  assign s1_free  = !s1_valid || res_free;
  assign accept   = grant_any && s1_free;

  // Operands of the granted requester, and the full-width product.
  assign sel_a    = bus.req_a[int'(grant_idx)*A_W +: A_W];
  assign sel_b    = bus.req_b[int'(grant_idx)*B_W +: B_W];
  assign product  = C_W'(s1_a) * C_W'(s1_b);
  assign ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Ready is forced low while reset is held so nothing looks accepted.
  assign bus.req_ready = grant & {N_REQ{s1_free && rst}};
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = s1_valid || res_valid_q;
  assign bus.op_count  = op_count_q;

  // Issue register: capture the granted operands, empty when passed on.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
      s1_id    <= grant_idx;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Result register: load the product, hold under backpressure, clear
  // once taken with nothing behind it.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else if (s1_adv) begin
      res_valid_q <= 1'b1;
      res_data_q  <= product;
      res_id_q    <= s1_id;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  // Pointer moves past the winner and the counter wraps freely on accept.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      op_count_q <= '0;
    end else if (accept) begin
      ptr        <= ptr_next;
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: directed vectors, multi-cycle sequences and random
// traffic checked against a queue-based reference model.
module tb_mul_sched;
  import mul_sched_pkg::*;

  localparam int N_REQ = N_REQ_DEF;
  localparam int A_W   = A_W_DEF;
  localparam int B_W   = B_W_DEF;
  localparam int C_W   = C_W_DEF;
  localparam int ID_W  = ID_W_DEF;
  localparam int CNT_W = 5;  // narrow so counter wrap happens in a short run
  localparam int REC_W = C_W + ID_W;

  typedef struct {
    int id;
    int a;
    int b;
    int exp_data;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic rst;
  always #5 sysclk = ~sysclk;

  mul_sched_if #(.N_REQ(N_REQ), .A_W(A_W), .B_W(B_W), .CNT_W(CNT_W)) bus ();

  mul_sched #(.N_REQ(N_REQ), .A_W(A_W), .B_W(B_W), .CNT_W(CNT_W)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [REC_W-1:0] exp_q[$];
  int               mptr;
  int               mcount;
  int               n_checks;
  int               n_errors;
  logic [N_REQ-1:0] last_grant;
  vec_t             vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input int a, input int b);
    bus.req_valid[i]           = v;
    bus.req_a[i*A_W +: A_W]    = A_W'(a);
    bus.req_b[i*B_W +: B_W]    = B_W'(b);
  endtask

  // One clock cycle. The model only knows: at most two operations are in
  // flight, a new one can enter unless two are held and the consumer stalls,
  // the winner is the first valid requester at/after the last winner + 1,
  // and results come back in accept order as a*b.
  task automatic tick();
    logic [N_REQ-1:0] eg;
    res_rec_t         r;
    int               g;
    int               pa;
    int               pb;
    bit               can_take;
    #1;
    can_take = (exp_q.size() < 2) || bus.res_ready;
    eg = '0;
    g  = -1;
    if (can_take) begin
      for (int k = 0; k < N_REQ; k++) begin
        int j;
        j = (mptr + k) % N_REQ;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(eg));
    check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
    check("op_count", 32'(bus.op_count), 32'(mcount % (1 << CNT_W)));
    if (bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        check("res_extra", 32'(bus.res_valid & bus.res_ready), 32'(0));
      end else begin
        r = res_rec_t'(exp_q.pop_front());
        check("res_data", 32'(bus.res_data), 32'(r.data));
        check("res_id", 32'(bus.res_id), 32'(r.id));
      end
    end
    if (g >= 0) begin
      pa = int'(bus.req_a[g*A_W +: A_W]);
      pb = int'(bus.req_b[g*B_W +: B_W]);
      exp_q.push_back({C_W'(pa * pb), ID_W'(g)});
      mptr   = (g + 1) % N_REQ;
      mcount = mcount + 1;
    end
    last_grant = eg;
    @(posedge sysclk);
    #1;
  endtask

  task automatic drain(input int cycles);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (cycles) tick();
    check("drained", 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [C_W-1:0] held;
    int             acc;

    n_checks = 0;
    n_errors = 0;
    mptr = 0;
    mcount = 0;
    last_grant = '0;
    vecs[0] = '{id: 2, a: 5,  b: 3, exp_data: 15};
    vecs[1] = '{id: 0, a: 15, b: 7, exp_data: 105};
    vecs[2] = '{id: 3, a: 0,  b: 7, exp_data: 0};
    vecs[3] = '{id: 1, a: 15, b: 0, exp_data: 0};
    vecs[4] = '{id: 3, a: 9,  b: 5, exp_data: 45};
    vecs[5] = '{id: 1, a: 1,  b: 1, exp_data: 1};

    rst = 1'b0;
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    check("rst_res_valid", 32'(bus.res_valid), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_op_count", 32'(bus.op_count), 32'(0));
    check("rst_res_data", 32'(bus.res_data), 32'(0));
    check("rst_res_id", 32'(bus.res_id), 32'(0));
    check("rst_req_ready", 32'(bus.req_ready), 32'(0));
    bus.req_valid = '0;
    rst = 1'b1;

    // All four valid from reset: grants 0..3, results 1,4,9,16 back-to-back.
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, i + 1, i + 1);
    for (int t = 1; t <= 6; t++) begin
      if (t <= 4) begin
        #1;
        check("seq_grant", 32'(bus.req_ready), 32'(N_REQ'(1) << (t - 1)));
      end
      tick();
      if (t <= 4) bus.req_valid[t-1] = 1'b0;
      if (t == 1) check("seq_lat", 32'(bus.res_valid), 32'(0));
      if (t >= 2 && t <= 5) begin
        check("seq_valid", 32'(bus.res_valid), 32'(1));
        check("seq_data", 32'(bus.res_data), 32'((t - 1) * (t - 1)));
        check("seq_id", 32'(bus.res_id), 32'(t - 2));
      end
    end

    // Requesters 1 and 3 held: alternate 1,3,...; after 3 the pointer is 0.
    set_req(1, 1'b1, 7, 3);
    set_req(3, 1'b1, 2, 6);
    for (int t = 0; t < 6; t++) begin
      #1;
      check("rr_grant", 32'(bus.req_ready), (t % 2 == 0) ? 32'h2 : 32'h8);
      tick();
    end
    set_req(0, 1'b1, 4, 4);
    #1;
    check("rr_wrap", 32'(bus.req_ready), 32'h1);
    tick();
    drain(4);

    // Table of single requests: accept, two-cycle latency, exact product.
    foreach (vecs[v]) begin
      set_req(vecs[v].id, 1'b1, vecs[v].a, vecs[v].b);
      #1;
      check("tbl_accept", 32'(bus.req_ready), 32'(N_REQ'(1) << vecs[v].id));
      tick();
      bus.req_valid = '0;
      check("tbl_lat1", 32'(bus.res_valid), 32'(0));
      tick();
      check("tbl_valid", 32'(bus.res_valid), 32'(1));
      check("tbl_data", 32'(bus.res_data), 32'(vecs[v].exp_data));
      check("tbl_id", 32'(bus.res_id), 32'(vecs[v].id));
      tick();
    end

    // Backpressure: five stalled cycles take exactly two operations.
    bus.res_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      set_req(i, 1'b1, $urandom_range(0, 15), $urandom_range(0, 7));
    acc = 0;
    held = '0;
    for (int t = 0; t < 5; t++) begin
      #1;
      if (bus.req_ready != '0) acc++;
      tick();
      bus.req_valid = bus.req_valid & ~last_grant;
      if (t == 1) held = bus.res_data;
      if (t >= 2) begin
        check("bp_valid", 32'(bus.res_valid), 32'(1));
        check("bp_hold", 32'(bus.res_data), 32'(held));
      end
    end
    check("bp_inflight", 32'(acc), 32'(2));
    check("bp_ready0", 32'(bus.req_ready), 32'(0));
    bus.res_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      bus.req_valid = bus.req_valid & ~last_grant;
    end
    drain(3);

    // Random traffic; operands held while pending.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!(bus.req_valid[i] && !last_grant[i]))
          set_req(i, 1'($urandom_range(0, 99) < 60), $urandom_range(0, 15), $urandom_range(0, 7));
      end
      bus.res_ready = 1'($urandom_range(0, 99) < 70);
      tick();
    end
    drain(4);

    // Reset with both stages full: everything drops at once, no replay.
    bus.res_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, i + 9, 5);
    repeat (3) begin
      tick();
      bus.req_valid = bus.req_valid & ~last_grant;
    end
    bus.req_valid = '1;
    #2;
    rst = 1'b0;
    #1;
    check("mid_res_valid", 32'(bus.res_valid), 32'(0));
    check("mid_busy", 32'(bus.busy), 32'(0));
    check("mid_op_count", 32'(bus.op_count), 32'(0));
    check("mid_req_ready", 32'(bus.req_ready), 32'(0));
    exp_q.delete();
    mptr = 0;
    mcount = 0;
    last_grant = '0;
    repeat (2) @(posedge sysclk);
    #1;
    rst = 1'b1;
    bus.res_ready = 1'b1;
    #1;
    check("mid_first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    drain(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
